// File: rtl/vec_issue_pkg.sv
// vec_issue_pkg: shared types and constants for the vector issue sequencer.
//   - state_t : sequencer FSM states
//   - entry_t : one queued operation (launch fields precomputed at accept)
//   - SEW/LMUL encodings used on the cfg_* inputs
// entry_t field widths are fixed here; the top-level ADDR_WIDTH and OFF_WIDTH
// parameters must stay equal to PKG_ADDR_WIDTH and PKG_OFF_WIDTH.
package vec_issue_pkg;

    localparam int unsigned PKG_ADDR_WIDTH = 5;
    localparam int unsigned PKG_OFF_WIDTH  = 8;

    localparam logic [1:0] SEW_8   = 2'd0;
    localparam logic [1:0] SEW_16  = 2'd1;
    localparam logic [1:0] SEW_32  = 2'd2;
    localparam logic [1:0] SEW_64  = 2'd3;

    localparam logic [1:0] LMUL_1  = 2'd0;
    localparam logic [1:0] LMUL_2  = 2'd1;
    localparam logic [1:0] LMUL_4  = 2'd2;
    localparam logic [1:0] LMUL_8  = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic [1:0]                sew;
        logic [2:0]                max_reg;
        logic [PKG_OFF_WIDTH-1:0]  max_off;
        logic                      whole_reg;
        logic                      widen;
    } entry_t;

endpackage

// File: rtl/vec_issue_fifo.sv
// vec_issue_fifo: synchronous FIFO of entry_t with asynchronous active-low reset.
// Ports:
//   clk, rst_n           clock / async active-low reset (flushes pointers)
//   push, push_data      write request and data (ignored when full)
//   pop, pop_data        read request (ignored when empty); pop_data shows the head
//   full, empty          occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vec_issue_fifo
    import vec_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_q, rd_q;
    entry_t         mem [DEPTH];

    logic do_push, do_pop;

    assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign empty    = (wr_q == rd_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/vec_issue_seq.sv
// vec_issue_seq: issue sequencer in front of the vector address generator.
// Holds vl/SEW/LMUL, queues register-group operations with their last-beat
// register/offset precomputed, and launches them one at a time.
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   cfg_valid, cfg_avl, cfg_sew,
//   cfg_lmul, vl_out                   configuration load and current vl
//   inst_valid, inst_ready, inst_addr,
//   inst_whole_reg, inst_widen         operation handshake
//   agu_en, agu_addr, agu_sew,
//   agu_max_reg, agu_max_off, agu_off,
//   agu_whole_reg, agu_widen, agu_idle launch interface to the address generator
//   busy                               queue non-empty or FSM not idle
// Build option: define VEC_ISSUE_BYPASS_EN to let an operation arriving while
// everything is idle skip the queue and launch one cycle earlier.
module vec_issue_seq
    import vec_issue_pkg::*;
#(
    parameter int unsigned VLEN        = 16384,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = PKG_ADDR_WIDTH,
    parameter int unsigned OFF_WIDTH   = $clog2(VLEN / DATA_WIDTH),
    parameter int unsigned VL_WIDTH    = $clog2(VLEN) + 1,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    input  logic [VL_WIDTH-1:0]   cfg_avl,
    input  logic [1:0]            cfg_sew,
    input  logic [1:0]            cfg_lmul,
    output logic [VL_WIDTH-1:0]   vl_out,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_whole_reg,
    input  logic                  inst_widen,
    output logic                  agu_en,
    output logic [ADDR_WIDTH-1:0] agu_addr,
    output logic [1:0]            agu_sew,
    output logic [2:0]            agu_max_reg,
    output logic [OFF_WIDTH-1:0]  agu_max_off,
    output logic [OFF_WIDTH-1:0]  agu_off,
    output logic                  agu_whole_reg,
    output logic                  agu_widen,
    input  logic                  agu_idle,
    output logic                  busy
);

    localparam int unsigned VLMAX_BASE = VLEN / 8;
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned BYTES_W    = VL_WIDTH + 3;

    // Active configuration
    logic [VL_WIDTH-1:0] vl_q;
    logic [1:0]          sew_q, lmul_q;
    logic [VL_WIDTH-1:0] vlmax, cfg_vl;

    assign vlmax  = VL_WIDTH'(VLMAX_BASE >> cfg_sew) << cfg_lmul;
    assign cfg_vl = (cfg_avl < vlmax) ? cfg_avl : vlmax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_q   <= '0;
            sew_q  <= SEW_8;
            lmul_q <= LMUL_1;
        end else if (cfg_valid) begin
            vl_q   <= cfg_vl;
            sew_q  <= cfg_sew;
            lmul_q <= cfg_lmul;
        end
    end

    assign vl_out = vl_q;

    // Beat math on the config registered before this cycle's cfg_valid.
    logic [BYTES_W-1:0] bytes, beats, last;
    entry_t             new_entry;

    assign bytes = BYTES_W'(vl_q) << sew_q;
    assign beats = (bytes + BYTES_W'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
    assign last  = beats - 1'b1;

    always_comb begin
        new_entry           = '0;
        new_entry.addr      = inst_addr;
        new_entry.sew       = sew_q;
        new_entry.max_reg   = 3'(last >> OFF_WIDTH);
        new_entry.max_off   = last[OFF_WIDTH-1:0];
        new_entry.whole_reg = inst_whole_reg;
        new_entry.widen     = inst_widen;
    end

    // Queue
    logic   fifo_full, fifo_empty, push, pop, accept, enq_ok, bypass;
    entry_t head;
    state_t state_q, state_d;

    assign inst_ready = !fifo_full;
    assign accept     = inst_valid && inst_ready;
    // vl==0 non-whole-register ops are consumed without ever launching.
    assign enq_ok     = inst_whole_reg || (vl_q != '0);

`ifdef VEC_ISSUE_BYPASS_EN
    assign bypass = accept && enq_ok && fifo_empty && (state_q == StIdle) && agu_idle;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && enq_ok && !bypass;

    vec_issue_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (new_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Launch FSM
    logic   load;
    entry_t load_entry;
    entry_t out_q;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load       = 1'b0;
        load_entry = head;
        unique case (state_q)
            StIdle: begin
                if (bypass) begin
                    load       = 1'b1;
                    load_entry = new_entry;
                    state_d    = StLaunch;
                end else if (!fifo_empty && agu_idle) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: state_d = StWait;
            StWait:   if (agu_idle) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) out_q <= load_entry;
        end
    end

    assign agu_en        = (state_q == StLaunch);
    assign agu_addr      = out_q.addr;
    assign agu_sew       = out_q.sew;
    assign agu_max_reg   = out_q.max_reg;
    assign agu_max_off   = out_q.max_off;
    assign agu_off       = '0;
    assign agu_whole_reg = out_q.whole_reg;
    assign agu_widen     = out_q.widen;
    assign busy          = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_vec_issue_seq.sv
// tb_vec_issue_seq: directed self-checking bench for vec_issue_seq.
module tb_vec_issue_seq;

    localparam int VL_W = 15;

`ifdef VEC_ISSUE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic            clk;
    logic            rst_n;
    logic            cfg_valid;
    logic [VL_W-1:0] cfg_avl;
    logic [1:0]      cfg_sew;
    logic [1:0]      cfg_lmul;
    logic [VL_W-1:0] vl_out;
    logic            inst_valid;
    logic            inst_ready;
    logic [4:0]      inst_addr;
    logic            inst_whole_reg;
    logic            inst_widen;
    logic            agu_en;
    logic [4:0]      agu_addr;
    logic [1:0]      agu_sew;
    logic [2:0]      agu_max_reg;
    logic [7:0]      agu_max_off;
    logic [7:0]      agu_off;
    logic            agu_whole_reg;
    logic            agu_widen;
    logic            agu_idle;
    logic            busy;

    vec_issue_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_avl        (cfg_avl),
        .cfg_sew        (cfg_sew),
        .cfg_lmul       (cfg_lmul),
        .vl_out         (vl_out),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_addr      (inst_addr),
        .inst_whole_reg (inst_whole_reg),
        .inst_widen     (inst_widen),
        .agu_en         (agu_en),
        .agu_addr       (agu_addr),
        .agu_sew        (agu_sew),
        .agu_max_reg    (agu_max_reg),
        .agu_max_off    (agu_max_off),
        .agu_off        (agu_off),
        .agu_whole_reg  (agu_whole_reg),
        .agu_widen      (agu_widen),
        .agu_idle       (agu_idle),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] s, input logic [1:0] l, input int avl);
        cfg_valid = 1'b1;
        cfg_sew   = s;
        cfg_lmul  = l;
        cfg_avl   = VL_W'(avl);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [4:0] a, input logic w, input logic d);
        inst_valid     = 1'b1;
        inst_addr      = a;
        inst_whole_reg = w;
        inst_widen     = d;
        chk({tag, " ready"}, 32'(inst_ready), 32'd1);
        step();
        inst_valid     = 1'b0;
        inst_whole_reg = 1'b0;
        inst_widen     = 1'b0;
    endtask

    // Waits (bounded) for agu_en and checks latency and launch fields.
    task automatic wait_launch(input string tag, input int exp_lat, input logic [4:0] a,
                               input logic [1:0] s, input logic [2:0] r, input logic [7:0] o);
        int lat;
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            if (agu_en === 1'b1) lat = i;
            else step();
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (lat >= 0) begin
            chk({tag, " addr"}, 32'(agu_addr), 32'(a));
            chk({tag, " sew"}, 32'(agu_sew), 32'(s));
            chk({tag, " max_reg"}, 32'(agu_max_reg), 32'(r));
            chk({tag, " max_off"}, 32'(agu_max_off), 32'(o));
        end
    endtask

    int         times [$];
    logic [4:0] addrs [$];
    logic       wregs [$];
    logic       wides [$];
    logic       saw;

    initial begin
        rst_n          = 1'b0;
        cfg_valid      = 1'b0;
        cfg_avl        = '0;
        cfg_sew        = 2'd0;
        cfg_lmul       = 2'd0;
        inst_valid     = 1'b0;
        inst_addr      = '0;
        inst_whole_reg = 1'b0;
        inst_widen     = 1'b0;
        agu_idle       = 1'b1;
        step();
        step();
        chk("rst agu_en", 32'(agu_en), 32'd0);
        chk("rst agu_addr", 32'(agu_addr), 32'd0);
        chk("rst agu_max_reg", 32'(agu_max_reg), 32'd0);
        chk("rst agu_max_off", 32'(agu_max_off), 32'd0);
        chk("rst inst_ready", 32'(inst_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst vl_out", 32'(vl_out), 32'd0);
        rst_n = 1'b1;
        step();

        // vl clamps to VLMAX=2048; 256 beats -> reg 0, off 255
        set_cfg(2'd0, 2'd0, 20000);
        chk("t1 vl", 32'(vl_out), 32'd2048);
        issue("t1", 5'd8, 1'b0, 1'b0);
        wait_launch("t1", LAT, 5'd8, 2'd0, 3'd0, 8'd255);
        chk("t1 agu_off", 32'(agu_off), 32'd0);
        step();
        chk("t1 en pulse", 32'(agu_en), 32'd0);
        chk("t1 busy wait", 32'(busy), 32'd1);
        step();
        step();
        chk("t1 busy idle", 32'(busy), 32'd0);

        // 1000 x 4B = 4000B = 500 beats -> last 499 = reg 1, off 243
        set_cfg(2'd2, 2'd2, 1000);
        chk("t2 vl", 32'(vl_out), 32'd1000);
        issue("t2", 5'd16, 1'b0, 1'b0);
        wait_launch("t2", LAT, 5'd16, 2'd2, 3'd1, 8'd243);
        repeat (4) step();

        // Full LMUL=8 group of bytes -> reg 7, off 255
        set_cfg(2'd0, 2'd3, 16384);
        chk("t3 vl", 32'(vl_out), 32'd16384);
        issue("t3", 5'd0, 1'b0, 1'b0);
        wait_launch("t3", LAT, 5'd0, 2'd0, 3'd7, 8'd255);
        repeat (4) step();
        set_cfg(2'd0, 2'd0, 0);
        chk("t3 vl zero", 32'(vl_out), 32'd0);
        issue("t3 zero", 5'd4, 1'b0, 1'b0);
        saw = 1'b0;
        repeat (8) begin
            if (agu_en !== 1'b0) saw = 1'b1;
            step();
        end
        chk("t3 zero no launch", 32'(saw), 32'd0);
        chk("t3 zero busy", 32'(busy), 32'd0);

        // Fill the queue while the AGU reports busy
        set_cfg(2'd0, 2'd0, 20000);
        agu_idle = 1'b0;
        issue("t4 op1", 5'd1, 1'b0, 1'b0);
        issue("t4 op2", 5'd2, 1'b1, 1'b0);
        issue("t4 op3", 5'd3, 1'b0, 1'b1);
        issue("t4 op4", 5'd4, 1'b1, 1'b1);
        inst_valid = 1'b1;
        inst_addr  = 5'd5;
        chk("t4 full ready", 32'(inst_ready), 32'd0);
        step();
        inst_valid = 1'b0;
        chk("t4 full busy", 32'(busy), 32'd1);
        agu_idle = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (agu_en === 1'b1) begin
                times.push_back(c);
                addrs.push_back(agu_addr);
                wregs.push_back(agu_whole_reg);
                wides.push_back(agu_widen);
            end
            step();
        end
        chk("t4 launch count", 32'(times.size()), 32'd4);
        for (int k = 0; k < times.size(); k++) begin
            chk("t4 order addr", 32'(addrs[k]), 32'(k + 1));
            chk("t4 whole_reg", 32'(wregs[k]), 32'((k == 1) || (k == 3)));
            chk("t4 widen", 32'(wides[k]), 32'(k >= 2));
            if (k > 0) chk("t4 spacing>=3", 32'((times[k] - times[k-1]) >= 3), 32'd1);
        end
        chk("t4 drained busy", 32'(busy), 32'd0);

        // Config change in the accept cycle only affects later ops
        cfg_valid  = 1'b1;
        cfg_sew    = 2'd3;
        cfg_lmul   = 2'd1;
        cfg_avl    = VL_W'(20000);
        inst_valid = 1'b1;
        inst_addr  = 5'd10;
        step();
        cfg_valid  = 1'b0;
        inst_valid = 1'b0;
        wait_launch("t5 old cfg", LAT, 5'd10, 2'd0, 3'd0, 8'd255);
        chk("t5 vl", 32'(vl_out), 32'd512);
        repeat (4) step();
        // 512 x 8B = 4096B = 512 beats -> reg 1, off 255
        issue("t5 new", 5'd11, 1'b0, 1'b0);
        wait_launch("t5 new cfg", LAT, 5'd11, 2'd3, 3'd1, 8'd255);
        repeat (4) step();

        // Reset while in WAIT with two ops queued
        issue("t6", 5'd20, 1'b0, 1'b0);
        wait_launch("t6", LAT, 5'd20, 2'd3, 3'd1, 8'd255);
        agu_idle = 1'b0;
        step();
        issue("t6 q1", 5'd21, 1'b0, 1'b0);
        issue("t6 q2", 5'd22, 1'b0, 1'b0);
        chk("t6 busy before rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 rst agu_en", 32'(agu_en), 32'd0);
        chk("t6 rst busy", 32'(busy), 32'd0);
        chk("t6 rst ready", 32'(inst_ready), 32'd1);
        chk("t6 rst agu_addr", 32'(agu_addr), 32'd0);
        step();
        rst_n    = 1'b1;
        agu_idle = 1'b1;
        saw      = 1'b0;
        repeat (8) begin
            if (agu_en !== 1'b0) saw = 1'b1;
            step();
        end
        chk("t6 no launch after rst", 32'(saw), 32'd0);
        chk("t6 vl reset", 32'(vl_out), 32'd0);
        // 100B = 13 beats -> reg 0, off 12
        set_cfg(2'd0, 2'd0, 100);
        chk("t6 vl", 32'(vl_out), 32'd100);
        issue("t6 new", 5'd23, 1'b0, 1'b0);
        wait_launch("t6 new", LAT, 5'd23, 2'd0, 3'd0, 8'd12);
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
